// File: rtl/memory_arbiter.sv
// memory_arbiter
//   Shares one single-port memory between instruction fetch and data access.
//   Data requests win over fetch; each access holds the port for WAIT_STATES
//   cycles and then returns data with a one-cycle ready pulse.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | port idle, arbitrating; ready pulses are issued in this state
//   FETCH | instruction fetch holds the port, wait counter running
//   DATA  | data read or write holds the port, wait counter running
//
// Ports
//   clk, rst                       clock, async active-high reset
//   fetchRequest/Address           IF-stage request
//   fetchData, fetchReady          fetched word and completion pulse
//   memAccessControl               10 read, 01 write, 00 none, 11 illegal
//   dataAddress, dataWriteData     data request address and store data
//   dataReadData, dataReady        load data and completion pulse
//   stall                          some request active and not completing
//   accessError                    sticky: illegal code seen while idle
//   memAddress/WriteData/Enable/WriteEnable, memReadData  memory port
//
// WAIT_STATES must be 1 or more.
module memory_arbiter #(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 16,
  parameter int WAIT_STATES = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fetchRequest,
  input  logic [ADDR_WIDTH-1:0] fetchAddress,
  output logic [DATA_WIDTH-1:0] fetchData,
  output logic                  fetchReady,
  input  logic [1:0]            memAccessControl,
  input  logic [ADDR_WIDTH-1:0] dataAddress,
  input  logic [DATA_WIDTH-1:0] dataWriteData,
  output logic [DATA_WIDTH-1:0] dataReadData,
  output logic                  dataReady,
  output logic                  stall,
  output logic                  accessError,
  output logic [ADDR_WIDTH-1:0] memAddress,
  output logic [DATA_WIDTH-1:0] memWriteData,
  output logic                  memEnable,
  output logic                  memWriteEnable,
  input  logic [DATA_WIDTH-1:0] memReadData
);

  localparam int CNT_W = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;

  typedef enum logic [1:0] {IDLE, FETCH, DATA} state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] wait_cnt;
  logic             write_flag;
  logic             data_req, fetch_req, illegal;
  logic             grant_data, grant_fetch;

  // A request seen alongside its own ready pulse is the one that just
  // finished, so it is masked for that cycle. This also lets a waiting
  // fetch win after every data completion.
  assign data_req    = ((memAccessControl == 2'b10) || (memAccessControl == 2'b01)) && !dataReady;
  assign fetch_req   = fetchRequest && !fetchReady;
  assign illegal     = (memAccessControl == 2'b11);
  assign grant_data  = (state == IDLE) && data_req;
  assign grant_fetch = (state == IDLE) && !data_req && !illegal && fetch_req;
  assign stall       = data_req || fetch_req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next     = state;
    memEnable      = 1'b0;
    memWriteEnable = 1'b0;
    case (state)
      IDLE: begin
        if (grant_data)       state_next = DATA;
        else if (grant_fetch) state_next = FETCH;
      end
      FETCH: begin
        memEnable = 1'b1;
        if (wait_cnt == '0) state_next = IDLE;
      end
      DATA: begin
        memEnable      = 1'b1;
        memWriteEnable = write_flag;
        if (wait_cnt == '0) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt     <= '0;
      write_flag   <= 1'b0;
      memAddress   <= '0;
      memWriteData <= '0;
      fetchData    <= '0;
      fetchReady   <= 1'b0;
      dataReadData <= '0;
      dataReady    <= 1'b0;
      accessError  <= 1'b0;
    end else begin
      fetchReady <= 1'b0;
      dataReady  <= 1'b0;
      if (grant_data) begin
        memAddress   <= dataAddress;
        memWriteData <= dataWriteData;
        write_flag   <= (memAccessControl == 2'b01);
        wait_cnt     <= CNT_W'(WAIT_STATES - 1);
      end else if (grant_fetch) begin
        memAddress <= fetchAddress;
        write_flag <= 1'b0;
        wait_cnt   <= CNT_W'(WAIT_STATES - 1);
      end else if (state != IDLE) begin
        if (wait_cnt == '0) begin
          if (state == FETCH) begin
            fetchData  <= memReadData;
            fetchReady <= 1'b1;
          end else begin
            if (!write_flag) dataReadData <= memReadData;
            dataReady <= 1'b1;
          end
        end else begin
          wait_cnt <= wait_cnt - CNT_W'(1);
        end
      end
      if ((state == IDLE) && illegal) accessError <= 1'b1;
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
module tb_memory_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fetchRequest = 1'b0;
  logic [15:0] fetchAddress = '0;
  logic [1:0]  memAccessControl = 2'b00;
  logic [15:0] dataAddress = '0;
  logic [15:0] dataWriteData = '0;
  logic [15:0] memReadData = '0;

  // instance 1: WAIT_STATES=1
  logic [15:0] fd1, drd1, ma1, mwd1;
  logic        fr1, dr1, st1, ae1, me1, mwe1;
  // instance 2: WAIT_STATES=2
  logic [15:0] fd2, drd2, ma2, mwd2;
  logic        fr2, dr2, st2, ae2, me2, mwe2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  memory_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .WAIT_STATES(1)) dut1 (
    .clk(clk), .rst(rst),
    .fetchRequest(fetchRequest), .fetchAddress(fetchAddress),
    .fetchData(fd1), .fetchReady(fr1),
    .memAccessControl(memAccessControl), .dataAddress(dataAddress),
    .dataWriteData(dataWriteData), .dataReadData(drd1), .dataReady(dr1),
    .stall(st1), .accessError(ae1),
    .memAddress(ma1), .memWriteData(mwd1), .memEnable(me1),
    .memWriteEnable(mwe1), .memReadData(memReadData)
  );

  memory_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .WAIT_STATES(2)) dut2 (
    .clk(clk), .rst(rst),
    .fetchRequest(fetchRequest), .fetchAddress(fetchAddress),
    .fetchData(fd2), .fetchReady(fr2),
    .memAccessControl(memAccessControl), .dataAddress(dataAddress),
    .dataWriteData(dataWriteData), .dataReadData(drd2), .dataReady(dr2),
    .stall(st2), .accessError(ae2),
    .memAddress(ma2), .memWriteData(mwd2), .memEnable(me2),
    .memWriteEnable(mwe2), .memReadData(memReadData)
  );

  // Inputs change 1 time unit after the rising edge; outputs are sampled
  // on the falling edge of the same cycle.
  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic sample;
    @(negedge clk);
  endtask

  task automatic do_reset;
    rst = 1'b1;
    fetchRequest = 1'b0; fetchAddress = '0;
    memAccessControl = 2'b00; dataAddress = '0; dataWriteData = '0;
    memReadData = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #3;
    checks++;
    if ({fr1, dr1, me1, mwe1, ae1, st1, fd1, drd1, ma1, mwd1} !== 70'd0) begin
      errors++;
      $display("FAIL reset_dut1: got %h expected 0", {fr1, dr1, me1, mwe1, ae1, st1, fd1, drd1, ma1, mwd1});
    end
    checks++;
    if ({fr2, dr2, me2, mwe2, ae2, st2, fd2, drd2, ma2, mwd2} !== 70'd0) begin
      errors++;
      $display("FAIL reset_dut2: got %h expected 0", {fr2, dr2, me2, mwe2, ae2, st2, fd2, drd2, ma2, mwd2});
    end
    do_reset();
  endtask

  task automatic test_fetch;
    do_reset();
    tick(); fetchRequest = 1'b1; fetchAddress = 16'h0010; memReadData = 16'hABCD;
    sample();
    checks++; if (st1 !== 1'b1) begin errors++; $display("FAIL fetch_c0_stall: got %b expected 1", st1); end
    checks++; if (me1 !== 1'b0) begin errors++; $display("FAIL fetch_c0_en: got %b expected 0", me1); end
    tick(); sample();
    checks++; if (me1 !== 1'b1) begin errors++; $display("FAIL fetch_c1_en: got %b expected 1", me1); end
    checks++; if (ma1 !== 16'h0010) begin errors++; $display("FAIL fetch_c1_addr: got %h expected 0010", ma1); end
    checks++; if (mwe1 !== 1'b0) begin errors++; $display("FAIL fetch_c1_we: got %b expected 0", mwe1); end
    checks++; if (st1 !== 1'b1) begin errors++; $display("FAIL fetch_c1_stall: got %b expected 1", st1); end
    tick(); sample();
    checks++; if (fr1 !== 1'b1) begin errors++; $display("FAIL fetch_c2_ready: got %b expected 1", fr1); end
    checks++; if (fd1 !== 16'hABCD) begin errors++; $display("FAIL fetch_c2_data: got %h expected abcd", fd1); end
    checks++; if (st1 !== 1'b0) begin errors++; $display("FAIL fetch_c2_stall: got %b expected 0", st1); end
    checks++; if (me1 !== 1'b0) begin errors++; $display("FAIL fetch_c2_en: got %b expected 0", me1); end
    tick(); fetchRequest = 1'b0; memReadData = 16'h0000;
    sample();
    checks++; if (fr1 !== 1'b0) begin errors++; $display("FAIL fetch_c3_ready: got %b expected 0", fr1); end
    checks++; if (fd1 !== 16'hABCD) begin errors++; $display("FAIL fetch_c3_hold: got %h expected abcd", fd1); end
  endtask

  task automatic test_back_to_back;
    do_reset();
    tick(); fetchRequest = 1'b1; fetchAddress = 16'h0020; memReadData = 16'h0F0F;
    sample();
    tick(); sample();
    tick(); sample();
    checks++; if ({fr1, me1} !== 2'b10) begin errors++; $display("FAIL b2b_c2: got ready,en=%b expected 10", {fr1, me1}); end
    tick(); sample();
    checks++; if ({me1, st1} !== 2'b01) begin errors++; $display("FAIL b2b_c3_idle: got en,stall=%b expected 01", {me1, st1}); end
    tick(); sample();
    checks++; if (me1 !== 1'b1) begin errors++; $display("FAIL b2b_c4_en: got %b expected 1", me1); end
    tick(); sample();
    checks++; if (fr1 !== 1'b1) begin errors++; $display("FAIL b2b_c5_ready: got %b expected 1", fr1); end
    tick(); fetchRequest = 1'b0;
  endtask

  task automatic test_load_store;
    int  we_cnt;
    bit  addr_bad, done;
    do_reset();
    tick(); memAccessControl = 2'b10; dataAddress = 16'h0020; memReadData = 16'h5A5A;
    sample();
    tick(); sample();
    tick(); sample();
    checks++; if (dr1 !== 1'b1) begin errors++; $display("FAIL load_ready: got %b expected 1", dr1); end
    checks++; if (drd1 !== 16'h5A5A) begin errors++; $display("FAIL load_data: got %h expected 5a5a", drd1); end
    tick(); memAccessControl = 2'b00;
    sample();
    tick(); memAccessControl = 2'b01; dataAddress = 16'h0040; dataWriteData = 16'h1234;
    memReadData = 16'hFFFF;
    we_cnt = 0; addr_bad = 1'b0; done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      sample();
      if (mwe1 === 1'b1) begin
        we_cnt++;
        if (ma1 !== 16'h0040 || mwd1 !== 16'h1234) addr_bad = 1'b1;
      end
      if (dr1 === 1'b1) begin
        done = 1'b1;
        break;
      end
      tick();
    end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL store_ready: got %b expected 1 within 10 cycles", done); end
    checks++; if (we_cnt != 1) begin errors++; $display("FAIL store_we_cycles: got %0d expected 1", we_cnt); end
    checks++; if (addr_bad !== 1'b0) begin errors++; $display("FAIL store_port: got bad addr/data expected 0040/1234"); end
    checks++; if (drd1 !== 16'h5A5A) begin errors++; $display("FAIL store_rdata_kept: got %h expected 5a5a", drd1); end
    tick(); memAccessControl = 2'b00;
    sample();
    checks++; if ({dr1, mwe1} !== 2'b00) begin errors++; $display("FAIL store_after: got ready,we=%b expected 00", {dr1, mwe1}); end
  endtask

  task automatic test_simultaneous;
    do_reset();
    tick(); fetchRequest = 1'b1; fetchAddress = 16'h0100;
    memAccessControl = 2'b10; dataAddress = 16'h0200; memReadData = 16'h1111;
    sample();
    checks++; if ({st2, me2} !== 2'b10) begin errors++; $display("FAIL sim_c0: got stall,en=%b expected 10", {st2, me2}); end
    tick(); sample();
    checks++; if ({me2, ma2} !== {1'b1, 16'h0200}) begin errors++; $display("FAIL sim_c1: got en,addr=%b,%h expected 1,0200", me2, ma2); end
    tick(); sample();
    checks++; if ({me2, st2, dr2} !== 3'b110) begin errors++; $display("FAIL sim_c2: got en,stall,dready=%b expected 110", {me2, st2, dr2}); end
    tick(); sample();
    checks++; if ({dr2, st2, me2, fr2} !== 4'b1100) begin errors++; $display("FAIL sim_c3: got dready,stall,en,fready=%b expected 1100", {dr2, st2, me2, fr2}); end
    checks++; if (drd2 !== 16'h1111) begin errors++; $display("FAIL sim_load_data: got %h expected 1111", drd2); end
    tick(); memAccessControl = 2'b00; memReadData = 16'h2222;
    sample();
    checks++; if ({me2, ma2, st2} !== {1'b1, 16'h0100, 1'b1}) begin errors++; $display("FAIL sim_c4: got en,addr,stall=%b,%h,%b expected 1,0100,1", me2, ma2, st2); end
    tick(); sample();
    checks++; if ({st2, fr2} !== 2'b10) begin errors++; $display("FAIL sim_c5: got stall,fready=%b expected 10", {st2, fr2}); end
    tick(); sample();
    checks++; if ({fr2, st2} !== 2'b10) begin errors++; $display("FAIL sim_c6: got fready,stall=%b expected 10", {fr2, st2}); end
    checks++; if (fd2 !== 16'h2222) begin errors++; $display("FAIL sim_fetch_data: got %h expected 2222", fd2); end
    tick(); fetchRequest = 1'b0;
  endtask

  task automatic test_illegal;
    do_reset();
    tick(); memAccessControl = 2'b11;
    sample();
    checks++; if ({me1, ae1} !== 2'b00) begin errors++; $display("FAIL illegal_c0: got en,err=%b expected 00", {me1, ae1}); end
    tick(); memAccessControl = 2'b00;
    sample();
    checks++; if ({me1, ae1} !== 2'b01) begin errors++; $display("FAIL illegal_c1: got en,err=%b expected 01", {me1, ae1}); end
    tick(); sample();
    checks++; if ({me1, ae1} !== 2'b01) begin errors++; $display("FAIL illegal_sticky: got en,err=%b expected 01", {me1, ae1}); end
    do_reset();
    sample();
    checks++; if (ae1 !== 1'b0) begin errors++; $display("FAIL illegal_cleared: got %b expected 0", ae1); end
  endtask

  task automatic test_reset_mid_write;
    bit ready_seen;
    do_reset();
    tick(); memAccessControl = 2'b01; dataAddress = 16'h0080; dataWriteData = 16'hBEEF;
    sample();
    tick(); sample();
    checks++; if ({me2, mwe2} !== 2'b11) begin errors++; $display("FAIL midrst_before: got en,we=%b expected 11", {me2, mwe2}); end
    #1 rst = 1'b1;
    #1;
    checks++; if ({me2, mwe2, dr2} !== 3'b000) begin errors++; $display("FAIL midrst_drop: got en,we,dready=%b expected 000", {me2, mwe2, dr2}); end
    @(posedge clk); #1 rst = 1'b0; memAccessControl = 2'b00;
    ready_seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sample();
      if (dr1 === 1'b1 || dr2 === 1'b1) ready_seen = 1'b1;
      tick();
    end
    checks++; if (ready_seen !== 1'b0) begin errors++; $display("FAIL midrst_no_ready: got %b expected 0", ready_seen); end
    fetchRequest = 1'b1; fetchAddress = 16'h0030; memReadData = 16'h7777;
    sample();
    tick(); sample();
    checks++; if ({me1, fr1} !== 2'b10) begin errors++; $display("FAIL midrst_fetch_c1: got en,fready=%b expected 10", {me1, fr1}); end
    tick(); sample();
    checks++; if ({fr1, fd1} !== {1'b1, 16'h7777}) begin errors++; $display("FAIL midrst_fetch_c2: got fready,data=%b,%h expected 1,7777", fr1, fd1); end
    tick(); fetchRequest = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_back_to_back();
    test_load_store();
    test_simultaneous();
    test_illegal();
    test_reset_mid_write();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no completion expected finish before 200000");
    $fatal(1);
  end

endmodule

// File: doc/memory_arbiter.md
# memory_arbiter

- Shares the single-port unified memory between the instruction-fetch stage and the data-memory stage of the pipeline.
- Data accesses come from `memAccessControl`, as decoded by the control unit. The arbiter sequences each access through a fixed number of memory wait states.
- It returns read data and a one-cycle ready pulse to the requester, and drives `stall` to freeze the pipeline while a request is outstanding.

## Interface

Reset scheme (already decided): one clock; reset is asynchronous and active-high.

Parameters:
- `ADDR_WIDTH`, 16: width of all address buses.
- `DATA_WIDTH`, 16: width of all data buses.
- `WAIT_STATES`, 1: cycles the memory port is held per access. Legal range is 1 or more; 0 is illegal.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `fetchRequest`  in  1  IF stage wants an instruction word.
- `fetchAddress`  in  ADDR_WIDTH  instruction address; held stable while `fetchRequest` is high.
- `fetchData`  out  DATA_WIDTH  instruction word; valid when `fetchReady` is high, holds its value afterwards.
- `fetchReady`  out  1  one-cycle pulse: the fetch has completed.
- `memAccessControl`  in  2  from the control unit. 2'b10 = read, 2'b01 = write, 2'b00 = none, 2'b11 = illegal.
- `dataAddress`  in  ADDR_WIDTH  data address; held while the request is active.
- `dataWriteData`  in  DATA_WIDTH  store data.
- `dataReadData`  out  DATA_WIDTH  load data; valid when `dataReady` is high after a read.
- `dataReady`  out  1  one-cycle pulse: the data access has completed.
- `stall`  out  1  combinational: some request is active and not completing this cycle.
- `accessError`  out  1  sticky flag: `memAccessControl` was 2'b11 while idle.
- `memAddress`  out  ADDR_WIDTH  memory port address.
- `memWriteData`  out  DATA_WIDTH  memory port write data.
- `memEnable`  out  1  memory port active.
- `memWriteEnable`  out  1  memory port write strobe.
- `memReadData`  in  DATA_WIDTH  memory port read data; valid in the last wait cycle.

## Operation

- States are IDLE, FETCH and DATA.
- Active-request definitions:
  - data request active = (`memAccessControl` is 10 or 01) and `dataReady` is low.
  - fetch request active = `fetchRequest` and `fetchReady` is low.
  - A request seen in the same cycle as its own ready pulse is the request that just completed, and is ignored.
- IDLE transitions (data has priority because it belongs to the older instruction):
  - Data request active: go to DATA.
  - Otherwise, fetch request active: go to FETCH.
  - Otherwise, stay in IDLE.
- On the grant edge:
  - Latch address, write data and the write flag into the port registers.
  - Load the wait counter with `WAIT_STATES`-1.
- FETCH and DATA:
  - `memEnable` is 1.
  - `memWriteEnable` is 1 only in a DATA write.
  - The counter decrements each cycle.
- Counter at 0, on the next edge:
  - Capture `memReadData` into `fetchData` (FETCH) or `dataReadData` (DATA read). A write leaves `dataReadData` unchanged.
  - Pulse the matching ready signal.
  - Return to IDLE.
- IDLE port outputs: `memEnable` and `memWriteEnable` are 0. `memAddress` and `memWriteData` hold their last values.
- `stall` = (data request active) | (fetch request active).
- Illegal code 2'b11 seen in IDLE: no access starts, and `accessError` is set to 1 until reset.
- Reset values: all outputs 0, state IDLE, counter 0, `accessError` 0.
- Reset asserted mid-access: the access is abandoned at once (asynchronously), `memWriteEnable` drops immediately, and no ready pulse is issued.

## Timing

- Access latency: a request raised in IDLE at cycle 0 is granted at edge 1. Ready and data are valid in cycle `WAIT_STATES`+1.
  - With `WAIT_STATES`=1: a 2-cycle latency.
  - A port-level access occupies `WAIT_STATES` cycles.
- Simultaneous requests: data is served first. Fetch is granted in the cycle `dataReady` pulses, so there is no idle bubble. Total cost is 2×(`WAIT_STATES`+1) cycles.
- Back-to-back requests from the same source: there is a single idle cycle between them, because the request is ignored during its own ready cycle.
- A request arriving while another access is in flight waits; `stall` stays high throughout.
- No starvation: the data request is masked for one cycle per completion, which lets a waiting fetch win.

## Test plan

- Single fetch, `WAIT_STATES`=1, address 0x0010, `memReadData`=0xABCD:
  - `memEnable` is 1 in cycle 1.
  - `fetchReady` pulses in cycle 2 with `fetchData`=0xABCD.
  - `stall` is 1 in cycles 0–1 and 0 in cycle 2.
- Store: `memAccessControl`=01, address 0x0040, data 0x1234:
  - `memWriteEnable` is 1 for exactly `WAIT_STATES` cycles with `memAddress`=0x0040.
  - `dataReady` pulses; `dataReadData` is unchanged.
- Fetch and load raised in the same cycle, `WAIT_STATES`=2:
  - The load is served first, with `dataReady` at cycle 3.
  - The fetch is granted in cycle 3, with `fetchReady` at cycle 6.
  - `stall` is high through cycle 5.
- `memAccessControl`=11 in IDLE:
  - No `memEnable`.
  - `accessError` goes to 1 next edge and stays 1 after the code returns to 00.
  - A later `rst` clears it.
- `rst` pulsed mid-write:
  - `memWriteEnable` and `memEnable` drop immediately.
  - No ready pulse.
  - A subsequent fetch completes with normal 2-cycle latency.
